// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Pipelined immediate generator for the decode stage.
//                Decodes instr[31:7] and a 3-bit format select into a sign- or
//                zero-extended XLEN-bit immediate, an illegal-format flag and a
//                pass-through tag. Valid/ready on both sides, with a 2-entry
//                FIFO output buffer so that decode can stall safely.
//  Ports       : clk, rst_n            clock / synchronous active-low reset
//                in_valid, in_ready    input handshake
//                instr, immsrc, in_tag instruction bits [31:7], format, sideband
//                out_valid, out_ready  output handshake
//                out_imm, out_illegal  head-entry immediate and illegal flag
//                out_tag               head-entry sideband tag
//                err_sticky            set by any accepted illegal format
//  Revision    : 1.0  initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      instr,
    input  logic [2:0]       immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic             err_sticky
);

    localparam logic [2:0] c_SRC_I     = 3'b000;
    localparam logic [2:0] c_SRC_S     = 3'b001;
    localparam logic [2:0] c_SRC_B     = 3'b010;
    localparam logic [2:0] c_SRC_J     = 3'b011;
    localparam logic [2:0] c_SRC_U     = 3'b100;
    localparam logic [2:0] c_SRC_SHAMT = 3'b101;

    // Packed buffer entry: {illegal, tag, immediate}
    localparam int ENT_W = XLEN + TAG_W + 1;

    // Re-index the input so bit positions match the instruction encoding
    logic [31:7]     w_ins;
    logic            w_s;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_shamt;
    logic [XLEN-1:0] w_imm;
    logic            w_ill;
    logic [ENT_W-1:0] w_new;

    assign w_ins = instr;
    assign w_s   = w_ins[31];

    // U-type and shift-amount formats are the only XLEN-dependent layouts
    generate
        if (XLEN == 32) begin : g_x32
            assign w_imm_u     = {w_ins[31:12], 12'b0};
            assign w_imm_shamt = {{(XLEN-5){1'b0}}, w_ins[24:20]};
        end else if (XLEN == 64) begin : g_x64
            assign w_imm_u     = {{(XLEN-32){w_s}}, w_ins[31:12], 12'b0};
            assign w_imm_shamt = {{(XLEN-6){1'b0}}, w_ins[25:20]};
        end else begin : g_xlen_bad
            $error("imm_gen_pipe: XLEN must be 32 or 64");
            assign w_imm_u     = '0;
            assign w_imm_shamt = '0;
        end
    endgenerate

    always_comb begin
        w_imm = '0;
        w_ill = 1'b0;
        case (immsrc)
            c_SRC_I:     w_imm = {{(XLEN-12){w_s}}, w_ins[31:20]};
            c_SRC_S:     w_imm = {{(XLEN-12){w_s}}, w_ins[31:25], w_ins[11:7]};
            c_SRC_B:     w_imm = {{(XLEN-12){w_s}}, w_ins[7], w_ins[30:25],
                                  w_ins[11:8], 1'b0};
            c_SRC_J:     w_imm = {{(XLEN-20){w_s}}, w_ins[19:12], w_ins[20],
                                  w_ins[30:21], 1'b0};
            c_SRC_U:     w_imm = w_imm_u;
            c_SRC_SHAMT: w_imm = w_imm_shamt;
            default:     w_ill = 1'b1;
        endcase
    end

    assign w_new = {w_ill, in_tag, w_imm};

    // ------------------------------------------------------------------------
    // Two-entry buffer. head_q is always the oldest entry; tail_q holds the
    // second one when count_q == 2. The head only changes on a pop or on a
    // push into an empty buffer, which keeps the output stable while stalled.
    // ------------------------------------------------------------------------
    logic [1:0]       count_q, count_d;
    logic [ENT_W-1:0] head_q,  head_d;
    logic [ENT_W-1:0] tail_q,  tail_d;
    logic             err_q,   err_d;
    logic             w_push;
    logic             w_pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        err_d   = err_q | (w_push & w_ill);
        case (count_q)
            2'd0: begin
                if (w_push) begin
                    head_d  = w_new;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (w_push && w_pop) begin
                    head_d = w_new;
                end else if (w_push) begin
                    tail_d  = w_new;
                    count_d = 2'd2;
                end else if (w_pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (w_pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            err_q   <= err_d;
        end
    end

    assign out_imm     = head_q[XLEN-1:0];
    assign out_tag     = head_q[XLEN+TAG_W-1:XLEN];
    assign out_illegal = head_q[ENT_W-1];
    assign err_sticky  = err_q;

endmodule
`default_nettype wire
